// File: rtl/multicycle_cpu_core.sv
// Parametrised multi-cycle core: a FETCH/DECODE/EXEC/MEM/WB/HALT control FSM with
// req/ready handshakes on separate instruction and data memory ports.
module multicycle_cpu_core #(
    parameter int                DATA_W   = 16,
    parameter int                REG_AW   = 3,
    parameter int                INSTR_W  = 26,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input  logic               CLK,
    input  logic               START,
    output logic               IM_REQ,
    output logic [DATA_W-1:0]  IM_ADDR,
    input  logic [INSTR_W-1:0] IM_RDATA,
    input  logic               IM_READY,
    output logic               DM_REQ,
    output logic               DM_WE,
    output logic [DATA_W-1:0]  DM_ADDR,
    output logic [DATA_W-1:0]  DM_WDATA,
    input  logic [DATA_W-1:0]  DM_RDATA,
    input  logic               DM_READY,
    output logic               RETIRE,
    output logic               HALTED,
    output logic               ILLEGAL,
    output logic [DATA_W-1:0]  PC_OUT
);

    localparam int IMM_W = INSTR_W - 6 - 2 * REG_AW;
    localparam int NREG  = 2 ** REG_AW;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_ir;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_b;
    logic [DATA_W-1:0]   r_aluout;
    logic [DATA_W-1:0]   r_mdr;
    logic [DATA_W-1:0]   r_regs [NREG];
    logic                r_im_req;
    logic                r_dm_req;
    logic                r_dm_we;
    logic                r_retire;
    logic                r_halted;
    logic                r_illegal;

    logic [5:0]          w_op;
    logic [REG_AW-1:0]   w_rs;
    logic [REG_AW-1:0]   w_rt;
    logic [IMM_W-1:0]    w_imm;
    logic [REG_AW-1:0]   w_rd;
    logic [5:0]          w_funct;
    logic [DATA_W-1:0]   w_imm_ext;
    logic                w_rtype_ok;
    logic                w_legal;
    logic [DATA_W-1:0]   w_alu;
    logic [REG_AW-1:0]   w_wb_idx;
    logic [DATA_W-1:0]   w_wb_data;

    assign w_op    = r_ir[INSTR_W-1 -: 6];
    assign w_rs    = r_ir[INSTR_W-7 -: REG_AW];
    assign w_rt    = r_ir[INSTR_W-7-REG_AW -: REG_AW];
    assign w_imm   = r_ir[IMM_W-1:0];
    assign w_rd    = w_imm[IMM_W-1 -: REG_AW];
    assign w_funct = w_imm[5:0];

    // Immediate is sign-extended, or simply truncated when wider than the datapath.
    if (IMM_W >= DATA_W) begin : g_imm_trunc
        assign w_imm_ext = w_imm[DATA_W-1:0];
    end else begin : g_imm_sext
        assign w_imm_ext = {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};
    end

    assign w_rtype_ok = (w_funct == F_ADD) || (w_funct == F_SUB) || (w_funct == F_AND) ||
                        (w_funct == F_OR)  || (w_funct == F_SLT);
    assign w_legal    = ((w_op == OP_RTYPE) && w_rtype_ok) || (w_op == OP_ADDI) ||
                        (w_op == OP_LW) || (w_op == OP_SW) || (w_op == OP_BEQ) || (w_op == OP_HALT);

    always_comb begin
        w_alu = r_a + w_imm_ext;
        if (w_op == OP_RTYPE) begin
            case (w_funct)
                F_SUB:   w_alu = r_a - r_b;
                F_AND:   w_alu = r_a & r_b;
                F_OR:    w_alu = r_a | r_b;
                F_SLT:   w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
                default: w_alu = r_a + r_b;
            endcase
        end
    end

    assign w_wb_idx  = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_wb_data = (w_op == OP_LW) ? r_mdr : r_aluout;

    // Outputs are registered and raised on the transition into the state that owns them,
    // so the first fetch after reset spends one cycle raising IM_REQ.
    always_ff @(posedge CLK or negedge START) begin
        if (!START) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_aluout  <= '0;
            r_mdr     <= '0;
            r_im_req  <= 1'b0;
            r_dm_req  <= 1'b0;
            r_dm_we   <= 1'b0;
            r_retire  <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_retire <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!r_im_req) begin
                        r_im_req <= 1'b1;
                    end else if (IM_READY) begin
                        r_ir     <= IM_RDATA;
                        r_pc     <= r_pc + DATA_W'(1);
                        r_im_req <= 1'b0;
                        r_state  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                    if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_retire <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (!w_legal) begin
                        r_illegal <= 1'b1;
                        r_retire  <= 1'b1;
                        r_im_req  <= 1'b1;
                        r_state   <= S_FETCH;
                    end else begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_aluout <= w_alu;
                    if (w_op == OP_BEQ) begin
                        if (r_a == r_b) begin
                            r_pc <= r_pc + w_imm_ext;
                        end
                        r_retire <= 1'b1;
                        r_im_req <= 1'b1;
                        r_state  <= S_FETCH;
                    end else if ((w_op == OP_LW) || (w_op == OP_SW)) begin
                        r_dm_req <= 1'b1;
                        r_dm_we  <= (w_op == OP_SW);
                        r_state  <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (r_dm_req && DM_READY) begin
                        r_dm_req <= 1'b0;
                        r_dm_we  <= 1'b0;
                        if (w_op == OP_SW) begin
                            r_retire <= 1'b1;
                            r_im_req <= 1'b1;
                            r_state  <= S_FETCH;
                        end else begin
                            r_mdr   <= DM_RDATA;
                            r_state <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (w_wb_idx != '0) begin
                        r_regs[w_wb_idx] <= w_wb_data;
                    end
                    r_retire <= 1'b1;
                    r_im_req <= 1'b1;
                    r_state  <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign IM_REQ   = r_im_req;
    assign IM_ADDR  = r_pc;
    assign DM_REQ   = r_dm_req;
    assign DM_WE    = r_dm_we;
    assign DM_ADDR  = r_aluout;
    assign DM_WDATA = r_b;
    assign RETIRE   = r_retire;
    assign HALTED   = r_halted;
    assign ILLEGAL  = r_illegal;
    assign PC_OUT   = r_pc;

endmodule
